// File: rtl/multiword_sub_stream.sv
// Streaming multi-precision subtractor: A - B - bin over LSW-first word beats,
// borrow chained across beats, one-cycle registered output with valid/ready.
module multiword_sub_stream #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_bin,
    input  logic             in_first,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_d,
    output logic             out_last,
    output logic             out_bout,
    output logic             out_zero,
    output logic             out_err
);

    typedef enum logic {IDLE, MID} state_t;

    state_t           state_q, state_d;
    logic             borrow_q, borrow_d;
    logic             zacc_q, zacc_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_d_q, out_d_d;
    logic             out_last_q, out_last_d;
    logic             out_bout_q, out_bout_d;
    logic             out_zero_q, out_zero_d;
    logic             out_err_q, out_err_d;

    logic             accept;
    logic             start;
    logic             proto_err;
    logic             bsel;
    logic [WIDTH:0]   diff;
    logic             zero_now;

    assign in_ready = ~out_valid_q | out_ready;
    assign accept   = in_valid & in_ready;

    // A stray non-first beat in IDLE still starts a packet; a first beat in MID restarts one.
    assign start     = in_first | (state_q == IDLE);
    assign proto_err = ((state_q == IDLE) & ~in_first) | ((state_q == MID) & in_first);
    assign bsel      = start ? in_bin : borrow_q;
    assign diff      = {1'b0, in_a} - {1'b0, in_b} - {{WIDTH{1'b0}}, bsel};
    assign zero_now  = (start | zacc_q) & (diff[WIDTH-1:0] == '0);

    always_comb begin
        state_d     = state_q;
        borrow_d    = borrow_q;
        zacc_d      = zacc_q;
        out_valid_d = out_valid_q & ~out_ready;
        out_d_d     = out_d_q;
        out_last_d  = out_last_q;
        out_bout_d  = out_bout_q;
        out_zero_d  = out_zero_q;
        out_err_d   = out_err_q;
        if (accept) begin
            out_valid_d = 1'b1;
            out_d_d     = diff[WIDTH-1:0];
            out_last_d  = in_last;
            out_bout_d  = in_last & diff[WIDTH];
            out_zero_d  = in_last & zero_now;
            borrow_d    = in_last ? 1'b0 : diff[WIDTH];
            zacc_d      = in_last ? 1'b1 : zero_now;
            state_d     = in_last ? IDLE : MID;
            if (proto_err) begin
                out_err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            borrow_q    <= 1'b0;
            zacc_q      <= 1'b1;
            out_valid_q <= 1'b0;
            out_d_q     <= '0;
            out_last_q  <= 1'b0;
            out_bout_q  <= 1'b0;
            out_zero_q  <= 1'b0;
            out_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            borrow_q    <= borrow_d;
            zacc_q      <= zacc_d;
            out_valid_q <= out_valid_d;
            out_d_q     <= out_d_d;
            out_last_q  <= out_last_d;
            out_bout_q  <= out_bout_d;
            out_zero_q  <= out_zero_d;
            out_err_q   <= out_err_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_d     = out_d_q;
    assign out_last  = out_last_q;
    assign out_bout  = out_bout_q;
    assign out_zero  = out_zero_q;
    assign out_err   = out_err_q;

endmodule

// File: tb/tb_multiword_sub_stream.sv
// Directed, table-driven bench for multiword_sub_stream (WIDTH=8) plus
// hand-written backpressure, protocol-error and async-reset sequences.
module tb_multiword_sub_stream;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_a = '0;
    logic [W-1:0] in_b = '0;
    logic         in_bin = 1'b0;
    logic         in_first = 1'b0;
    logic         in_last = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] out_d;
    logic         out_last;
    logic         out_bout;
    logic         out_zero;
    logic         out_err;

    int checks = 0;
    int errors = 0;

    multiword_sub_stream #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_bin(in_bin),
        .in_first(in_first), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_d(out_d), .out_last(out_last), .out_bout(out_bout),
        .out_zero(out_zero), .out_err(out_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         bin;
        logic         first;
        logic         last;
        logic [W-1:0] d;
        logic         last_o;
        logic         bout;
        logic         zero;
        logic         err;
    } vec_t;

    vec_t vecs[11];

    function automatic vec_t mk(input logic [W-1:0] a, input logic [W-1:0] b,
                                input logic bin, input logic first, input logic last,
                                input logic [W-1:0] d, input logic bout,
                                input logic zero, input logic err);
        vec_t v;
        v.a = a; v.b = b; v.bin = bin; v.first = first; v.last = last;
        v.d = d; v.last_o = last; v.bout = bout; v.zero = zero; v.err = err;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One beat, one cycle of latency, checked on the following negedge.
    task automatic apply(input string tag, input vec_t v);
        @(negedge clk);
        chk({tag, " in_ready"}, 32'(in_ready), 32'd1);
        in_a = v.a; in_b = v.b; in_bin = v.bin;
        in_first = v.first; in_last = v.last; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        $display("%s: a=%02h b=%02h bin=%0d f=%0d l=%0d -> d=%02h last=%0d bout=%0d zero=%0d err=%0d",
                 tag, v.a, v.b, v.bin, v.first, v.last, out_d, out_last, out_bout, out_zero, out_err);
        chk({tag, " out_valid"}, 32'(out_valid), 32'd1);
        chk({tag, " out_d"}, 32'(out_d), 32'(v.d));
        chk({tag, " out_last"}, 32'(out_last), 32'(v.last_o));
        chk({tag, " out_bout"}, 32'(out_bout), 32'(v.bout));
        chk({tag, " out_zero"}, 32'(out_zero), 32'(v.zero));
        chk({tag, " out_err"}, 32'(out_err), 32'(v.err));
    endtask

    logic [W+2:0] got[$];
    logic [W+2:0] exp_bp[3];
    int           idx;
    logic         acc;

    initial begin
        //              a      b      bin f  l  d      bout zero err
        vecs[0]  = mk(8'h05, 8'h03, 0, 1, 1, 8'h02, 0, 0, 0);
        vecs[1]  = mk(8'h00, 8'h01, 0, 1, 0, 8'hFF, 0, 0, 0);
        vecs[2]  = mk(8'h01, 8'h00, 0, 0, 1, 8'h00, 0, 0, 0);
        vecs[3]  = mk(8'h00, 8'h01, 0, 1, 0, 8'hFF, 0, 0, 0);
        vecs[4]  = mk(8'h00, 8'h00, 0, 0, 1, 8'hFF, 1, 0, 0);
        vecs[5]  = mk(8'h00, 8'h00, 1, 1, 1, 8'hFF, 1, 0, 0);
        vecs[6]  = mk(8'h34, 8'h34, 0, 1, 0, 8'h00, 0, 0, 0);
        vecs[7]  = mk(8'h12, 8'h12, 0, 0, 1, 8'h00, 0, 1, 0);
        vecs[8]  = mk(8'h34, 8'h33, 0, 1, 0, 8'h01, 0, 0, 0);
        vecs[9]  = mk(8'h12, 8'h12, 0, 0, 1, 8'h00, 0, 0, 0);
        vecs[10] = mk(8'hFF, 8'hFF, 1, 1, 1, 8'hFF, 1, 0, 0);

        // 0x010000 - 0x000001 as three beats: FF, FF, 00, no final borrow
        exp_bp[0] = {1'b0, 1'b0, 1'b0, 8'hFF};
        exp_bp[1] = {1'b0, 1'b0, 1'b0, 8'hFF};
        exp_bp[2] = {1'b1, 1'b0, 1'b0, 8'h00};

        #12 rst_n = 1'b1;
        @(negedge clk);
        chk("reset out_valid", 32'(out_valid), 32'd0);
        chk("reset in_ready", 32'(in_ready), 32'd1);
        chk("reset out_d", 32'(out_d), 32'd0);
        chk("reset out_err", 32'(out_err), 32'd0);
        chk("reset out_bout", 32'(out_bout), 32'd0);
        chk("reset out_zero", 32'(out_zero), 32'd0);

        for (int i = 0; i < 11; i++) apply($sformatf("vec%0d", i), vecs[i]);

        // Backpressure: output stalled for the first cycles of a 3-beat packet.
        idx = 0;
        got.delete();
        for (int cyc = 0; cyc < 12; cyc++) begin
            @(negedge clk);
            out_ready = (cyc >= 5);
            in_valid  = (idx < 3);
            in_a      = (idx == 2) ? 8'h01 : 8'h00;
            in_b      = (idx == 0) ? 8'h01 : 8'h00;
            in_bin    = 1'b0;
            in_first  = (idx == 0);
            in_last   = (idx == 2);
            #1;
            if (cyc >= 1 && cyc < 5) begin
                chk($sformatf("bp stall%0d in_ready", cyc), 32'(in_ready), 32'd0);
                chk($sformatf("bp stall%0d out_valid", cyc), 32'(out_valid), 32'd1);
                chk($sformatf("bp stall%0d out_d", cyc), 32'(out_d), 32'hFF);
            end
            acc = in_valid & in_ready;
            if (out_valid && out_ready) begin
                got.push_back({out_last, out_bout, out_zero, out_d});
                $display("bp beat%0d: d=%02h last=%0d bout=%0d zero=%0d",
                         got.size() - 1, out_d, out_last, out_bout, out_zero);
            end
            @(posedge clk);
            if (acc) idx++;
        end
        in_valid = 1'b0;
        chk("bp beat count", 32'(got.size()), 32'd3);
        for (int i = 0; i < 3; i++)
            if (i < got.size()) chk($sformatf("bp beat%0d", i), 32'(got[i]), 32'(exp_bp[i]));

        // Non-first beat while IDLE: treated as a start using in_bin (0x10-0x01-1).
        apply("err_idle", mk(8'h10, 8'h01, 1, 0, 1, 8'h0E, 0, 0, 1));

        // Async reset mid-packet, asserted between clock edges.
        apply("pre_rst", mk(8'h00, 8'h01, 0, 1, 0, 8'hFF, 0, 0, 1));
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        $display("async reset: out_valid=%0d out_err=%0d", out_valid, out_err);
        chk("arst out_valid", 32'(out_valid), 32'd0);
        chk("arst out_err", 32'(out_err), 32'd0);
        chk("arst in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        apply("post_rst", mk(8'h05, 8'h03, 0, 1, 1, 8'h02, 0, 0, 0));

        // First beat inside a packet: old borrow/zacc dropped, restart flagged.
        apply("abandon", mk(8'h00, 8'h01, 0, 1, 0, 8'hFF, 0, 0, 0));
        apply("restart", mk(8'h07, 8'h07, 0, 1, 0, 8'h00, 0, 0, 1));
        apply("restart_end", mk(8'h00, 8'h00, 0, 0, 1, 8'h00, 0, 1, 1));

        @(negedge clk);
        chk("drain out_valid", 32'(out_valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/multiword_sub_stream.md
Name: multiword_sub_stream

Overview:
Streaming multi-precision subtractor: computes A - B - bin for operands of arbitrary length. Operands arrive as WIDTH-bit words, least-significant word first, over a valid/ready handshake. Borrow chains across beats, so a k-beat packet subtracts k*WIDTH-bit numbers. It sits between operand sources and any datapath stage needing wide subtraction, magnitude compare or equality test, in place of a single-bit full subtractor chain.

Parameters:
WIDTH, 8, bits per operand word (>=1)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  input beat valid
in_ready  output  1  block can accept a beat
in_a  input  WIDTH  minuend word
in_b  input  WIDTH  subtrahend word
in_bin  input  1  initial borrow-in, sampled only on first beat
in_first  input  1  beat is least-significant word of a packet
in_last  input  1  beat is most-significant word of a packet
out_valid  output  1  output beat valid
out_ready  input  1  downstream accepts output beat
out_d  output  WIDTH  difference word
out_last  output  1  output beat ends packet
out_bout  output  1  final borrow-out (A < B + bin); meaningful only when out_last=1, else 0
out_zero  output  1  whole-packet difference is zero; meaningful only when out_last=1, else 0
out_err  output  1  sticky protocol-error flag

Behaviour:
- Reset (async, rst_n=0): out_valid=0, out_d=0, out_last=0, out_bout=0, out_zero=0, out_err=0, borrow register=0, zero accumulator=1, state=IDLE. in_ready=1 after reset.
- Handshake: in_ready = ~out_valid | out_ready (combinational). Input beat accepted when in_valid & in_ready. Output beat leaves when out_valid & out_ready. in_* must be held while in_valid=1 & in_ready=0.
- Latency: 1 cycle. An accepted beat appears on out_* on the next clock edge. Full throughput of 1 beat/cycle when out_ready=1.
- Arithmetic per accepted beat: bsel = (beat starts packet) ? in_bin : borrow register. Compute {b_out, d} = {1'b0,in_a} - {1'b0,in_b} - bsel in WIDTH+1 bits; b_out = bit WIDTH. d wraps modulo 2^WIDTH. Borrow register <= b_out, cleared to 0 on a last beat.
- Zero accumulator: zacc_next = (start ? 1 : zacc) & (d == 0). out_zero = zacc_next and out_bout = b_out on last beats only. Accumulator reset to 1 after a last beat.
- State machine:
  - IDLE: waiting for a first beat.
  - MID: inside a packet.
  - IDLE + in_first & ~in_last -> MID. IDLE + first&last -> IDLE (single-beat packet).
  - MID + in_last -> IDLE. MID + ~in_first & ~in_last -> MID.
- Protocol errors: all set out_err=1 (sticky until reset).
  - IDLE + beat with in_first=0: beat is treated as a packet start (uses in_bin).
  - MID + beat with in_first=1: previous packet is abandoned and the beat restarts (uses in_bin, zacc restarts).
- Output register holds while out_valid & ~out_ready. Simultaneous output drain and input accept in one cycle is legal.
- No accepted beat: out_valid <= 0 once drained. out_d etc. keep their last value.
- Reset mid-packet returns to IDLE with the borrow discarded. The next beat must carry in_first.

Test Plan:
1. WIDTH=8, single beat a=0x05 b=0x03 bin=0 first=last=1 -> next cycle out_d=0x02, out_bout=0, out_zero=0, out_last=1.
2. 0x0100-0x0001 as two beats: (a=0x00,b=0x01,first) then (a=0x01,b=0x00,last) -> out_d 0xFF then 0x00, final out_bout=0, out_zero=0.
3. 0x0000-0x0001 two beats -> out_d 0xFF, 0xFF, final out_bout=1. Also single beat 0x00-0x00 with bin=1 -> out_d=0xFF, out_bout=1.
4. 0x1234-0x1234 two beats -> out_d 0x34^0x34=0x00, 0x00, out_zero=1, out_bout=0. Repeat with 0x1234-0x1233 -> out_zero=0.
5. Backpressure: stream 3-beat packet with out_ready=0 for 4 cycles -> in_ready=0 after first accept, out_* stable. Release -> all beats delivered in order with correct borrow, no loss or duplication.
6. Errors and reset:
   - Non-first beat in IDLE -> out_err=1, result uses in_bin.
   - in_first in MID -> restart, out_err=1.
   - rst_n low mid-packet (async, between edges) -> out_valid=0 and out_err=0 immediately. Next packet computes correctly with no stale borrow.
